// File: rtl/rift2_wb_pkg.sv
// Shared types and constants for the Rift2 Wishbone bridge.
package rift2_wb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_ACK  = 2'd3
   } state_t;

   // CSR word offsets, selected by adr[3:2]
   localparam logic [1:0] CSR_CTRL   = 2'd0;
   localparam logic [1:0] CSR_BOOT   = 2'd1;
   localparam logic [1:0] CSR_STATUS = 2'd2;

   // Read data returned when the core never answers
   localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

   // CTRL reset: core held in reset, timeout irq disabled
   localparam logic [1:0]  CTRL_RST = 2'b01;
   localparam logic [31:0] BOOT_RST = 32'h8000_0000;

endpackage

// File: rtl/rift2_wb_timeout.sv
// Transaction watchdog: loaded when a forwarded access starts, counts down
// while the bridge is waiting on the core, flags expiry at terminal count.
module rift2_wb_timeout #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   // Loading TIMEOUT-1 makes expiry land in the TIMEOUT-th REQ/WAIT cycle
   localparam logic [15:0] LOAD = 16'(TIMEOUT - 1);

   logic [15:0] count;

   // Down-counter; holds at zero so a late ready can never wrap it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= LOAD;
      end else if (en && (count != '0)) begin
         count <= count - 16'd1;
      end
   end

   assign expired = en && (count == '0);

endmodule

// File: rtl/rift2_wb_bridge.sv
// Wishbone slave front end for rift2Wrap: local CSRs (core reset, boot
// address, timeout status) plus a single-outstanding forwarded window onto
// the core memory-load channel, with a watchdog for forward progress.
//
// state | meaning
// IDLE  | waiting for cyc&stb in our region; CSR accesses happen here
// REQ   | req_valid_o high, waiting for req_ready_i
// WAIT  | request accepted, waiting for rsp_valid_i
// ACK   | one-cycle Wishbone ack (suppressed if the master dropped cyc)
module rift2_wb_bridge
   import rift2_wb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int unsigned WIN_BITS  = 24,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_n,
   input  logic                wbs_cyc_i,
   input  logic                wbs_stb_i,
   input  logic                wbs_we_i,
   input  logic [3:0]          wbs_sel_i,
   input  logic [31:0]         wbs_adr_i,
   input  logic [31:0]         wbs_dat_i,
   output logic                wbs_ack_o,
   output logic [31:0]         wbs_dat_o,
   output logic                req_valid_o,
   input  logic                req_ready_i,
   output logic                req_we_o,
   output logic [WIN_BITS-2:0] req_addr_o,
   output logic [31:0]         req_wdata_o,
   output logic [3:0]          req_wstrb_o,
   input  logic                rsp_valid_i,
   input  logic [31:0]         rsp_rdata_i,
   output logic                core_rst_o,
   output logic [31:0]         boot_addr_o,
   output logic                timeout_irq_o
);

   state_t      state, state_nxt;
   logic        hit, is_csr, start_csr, start_win, csr_wr;
   logic        expired, tmo_en, timed_out;
   logic [1:0]  csr_idx;
   logic [31:0] csr_rdata, dat_nxt, boot_nxt;
   logic        ack_nxt, acc_we;
   logic        irq_en, irq_en_nxt, core_rst_nxt;
   logic        status_to, status_to_nxt;
   logic [7:0]  status_cnt, status_cnt_nxt;

   assign hit       = (wbs_adr_i[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
   assign is_csr    = wbs_adr_i[WIN_BITS-1];
   assign csr_idx   = wbs_adr_i[3:2];
   assign start_csr = (state == ST_IDLE) && wbs_cyc_i && wbs_stb_i && hit && is_csr;
   assign start_win = (state == ST_IDLE) && wbs_cyc_i && wbs_stb_i && hit && !is_csr;
   assign csr_wr    = start_csr && wbs_we_i;
   assign tmo_en    = (state == ST_REQ) || (state == ST_WAIT);

   // A response arriving in the expiry cycle still wins in WAIT
   assign timed_out = expired &&
                      ((state == ST_REQ) || ((state == ST_WAIT) && !rsp_valid_i));

   rift2_wb_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (wb_clk_i),
      .rst_n   (wb_rst_n),
      .clr     (start_win),
      .en      (tmo_en),
      .expired (expired)
   );

   // State register plus all registered outputs
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state         <= ST_IDLE;
         wbs_ack_o     <= 1'b0;
         wbs_dat_o     <= '0;
         req_valid_o   <= 1'b0;
         req_we_o      <= 1'b0;
         req_addr_o    <= '0;
         req_wdata_o   <= '0;
         req_wstrb_o   <= '0;
         core_rst_o    <= CTRL_RST[0];
         irq_en        <= CTRL_RST[1];
         boot_addr_o   <= BOOT_RST;
         status_to     <= 1'b0;
         status_cnt    <= '0;
         timeout_irq_o <= 1'b0;
      end else begin
         state         <= state_nxt;
         wbs_ack_o     <= ack_nxt;
         wbs_dat_o     <= dat_nxt;
         req_valid_o   <= (state_nxt == ST_REQ);
         core_rst_o    <= core_rst_nxt;
         irq_en        <= irq_en_nxt;
         boot_addr_o   <= boot_nxt;
         status_to     <= status_to_nxt;
         status_cnt    <= status_cnt_nxt;
         timeout_irq_o <= status_to_nxt && irq_en_nxt;
         if (start_win) begin
            req_we_o    <= wbs_we_i;
            req_addr_o  <= wbs_adr_i[WIN_BITS-2:0];
            req_wdata_o <= wbs_dat_i;
            req_wstrb_o <= wbs_sel_i;
         end
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start_csr)      state_nxt = ST_ACK;
            else if (start_win) state_nxt = ST_REQ;
         end
         ST_REQ: begin
            if (expired)          state_nxt = ST_ACK;
            else if (req_ready_i) state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (rsp_valid_i || expired) state_nxt = ST_ACK;
         end
         ST_ACK:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Next ack/read-data values; cyc is sampled on the edge that enters ACK
   always_comb begin
      acc_we  = (state == ST_IDLE) ? wbs_we_i : req_we_o;
      ack_nxt = (state_nxt == ST_ACK) && wbs_cyc_i;
      dat_nxt = '0;
      if (ack_nxt && !acc_we) begin
         if (state == ST_IDLE)  dat_nxt = csr_rdata;
         else if (timed_out)    dat_nxt = TIMEOUT_RDATA;
         else                   dat_nxt = rsp_rdata_i;
      end
   end

   // CSR read mux
   always_comb begin
      csr_rdata = '0;
      case (csr_idx)
         CSR_CTRL:   csr_rdata = {30'b0, irq_en, core_rst_o};
         CSR_BOOT:   csr_rdata = boot_addr_o;
         CSR_STATUS: csr_rdata = {16'b0, status_cnt, 7'b0, status_to};
         default:    csr_rdata = '0;
      endcase
   end

   // CSR write and timeout-status update
   always_comb begin
      core_rst_nxt   = core_rst_o;
      irq_en_nxt     = irq_en;
      boot_nxt       = boot_addr_o;
      status_to_nxt  = status_to;
      status_cnt_nxt = status_cnt;
      if (csr_wr) begin
         case (csr_idx)
            CSR_CTRL: begin
               if (wbs_sel_i[0]) begin
                  core_rst_nxt = wbs_dat_i[0];
                  irq_en_nxt   = wbs_dat_i[1];
               end
            end
            CSR_BOOT: begin
               for (int b = 0; b < 4; b++) begin
                  if (wbs_sel_i[b]) boot_nxt[8*b +: 8] = wbs_dat_i[8*b +: 8];
               end
            end
            CSR_STATUS: begin
               if (wbs_sel_i[0] && wbs_dat_i[0]) status_to_nxt = 1'b0;
            end
            default: ;
         endcase
      end
      if (timed_out) begin
         status_to_nxt = 1'b1;
         if (status_cnt != 8'hFF) status_cnt_nxt = status_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_rift2_wb_bridge.sv
// Directed bench for rift2_wb_bridge: CSR vector table plus hand sequences
// for forwarded accesses, timeout, cyc drop and mid-transaction reset.
module tb_rift2_wb_bridge;
   import rift2_wb_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, wdat;
   logic        ack;
   logic [31:0] rdat;
   logic        req_valid, req_ready, req_we;
   logic [22:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        core_rst;
   logic [31:0] boot_addr;
   logic        irq;

   int n_tests = 0;
   int n_fail  = 0;

   rift2_wb_bridge #(
      .BASE_ADDR (32'h3000_0000),
      .WIN_BITS  (24),
      .TIMEOUT   (8)
   ) dut (
      .wb_clk_i      (clk),
      .wb_rst_n      (rst_n),
      .wbs_cyc_i     (cyc),
      .wbs_stb_i     (stb),
      .wbs_we_i      (we),
      .wbs_sel_i     (sel),
      .wbs_adr_i     (adr),
      .wbs_dat_i     (wdat),
      .wbs_ack_o     (ack),
      .wbs_dat_o     (rdat),
      .req_valid_o   (req_valid),
      .req_ready_i   (req_ready),
      .req_we_o      (req_we),
      .req_addr_o    (req_addr),
      .req_wdata_o   (req_wdata),
      .req_wstrb_o   (req_wstrb),
      .rsp_valid_i   (rsp_valid),
      .rsp_rdata_i   (rsp_rdata),
      .core_rst_o    (core_rst),
      .boot_addr_o   (boot_addr),
      .timeout_irq_o (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic [31:0] exp_dat;
      logic        exp_core_rst;
      logic [31:0] exp_boot;
   } csr_vec_t;

   csr_vec_t vecs[13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   // Starts at a negedge, ends at the negedge where the next access may be driven
   task automatic csr_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic ack1, output logic [31:0] d1,
                          output logic ack2);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
      @(negedge clk);
      ack1 = ack; d1 = rdat;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(negedge clk);
      ack2 = ack;
   endtask

   // Cycle c is the cycle after edge c-1; stb is sampled at edge 0
   task automatic win_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int rdy_c, input int rsp_c,
                          input int drop_c, input logic [31:0] rsp_d,
                          output int ack_c, output logic [31:0] ack_d,
                          output logic rv1, output logic [31:0] ra1, output logic ack_after);
      ack_c = -1; ack_d = '0; rv1 = 1'b0; ra1 = '0;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
      for (int c = 1; c <= 20 && ack_c < 0; c++) begin
         @(negedge clk);
         if (c == 1) begin
            rv1 = req_valid;
            ra1 = 32'(req_addr);
         end
         if (ack) begin
            ack_c = c;
            ack_d = rdat;
         end
         req_ready = (c == rdy_c);
         rsp_valid = (c == rsp_c);
         rsp_rdata = rsp_d;
         if (c == drop_c) begin
            cyc = 1'b0; stb = 1'b0;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
      @(negedge clk);
      ack_after = ack;
   endtask

   initial begin
      logic        a1, a2, rv1, aa;
      logic [31:0] d1, ra1;
      int          ack_c, ack_cnt, rv_cnt;

      // we, adr, dat, sel, exp_dat, exp_core_rst, exp_boot
      vecs[0]  = '{1'b0, 32'h3080_0000, 32'h0,         4'hF, 32'h0000_0001, 1'b1, 32'h8000_0000};
      vecs[1]  = '{1'b0, 32'h3080_0004, 32'h0,         4'hF, 32'h8000_0000, 1'b1, 32'h8000_0000};
      vecs[2]  = '{1'b0, 32'h3080_0008, 32'h0,         4'hF, 32'h0000_0000, 1'b1, 32'h8000_0000};
      vecs[3]  = '{1'b0, 32'h3080_000C, 32'h0,         4'hF, 32'h0000_0000, 1'b1, 32'h8000_0000};
      vecs[4]  = '{1'b1, 32'h3080_0000, 32'h0000_0003, 4'b0010, 32'h0,      1'b1, 32'h8000_0000};
      vecs[5]  = '{1'b1, 32'h3080_0000, 32'hFFFF_FF00, 4'b0001, 32'h0,      1'b0, 32'h8000_0000};
      vecs[6]  = '{1'b0, 32'h3080_0000, 32'h0,         4'hF, 32'h0000_0000, 1'b0, 32'h8000_0000};
      vecs[7]  = '{1'b1, 32'h3080_0004, 32'h1234_5678, 4'b0101, 32'h0,      1'b0, 32'h8034_0078};
      vecs[8]  = '{1'b0, 32'h3080_0004, 32'h0,         4'hF, 32'h8034_0078, 1'b0, 32'h8034_0078};
      vecs[9]  = '{1'b1, 32'h3080_000C, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b0, 32'h8034_0078};
      vecs[10] = '{1'b0, 32'h3080_000C, 32'h0,         4'hF, 32'h0000_0000, 1'b0, 32'h8034_0078};
      vecs[11] = '{1'b1, 32'h3080_0008, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b0, 32'h8034_0078};
      vecs[12] = '{1'b0, 32'h3080_0008, 32'h0,         4'hF, 32'h0000_0000, 1'b0, 32'h8034_0078};

      rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
      req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_dat", rdat, 32'h0);
      chk("rst_req_valid", 32'(req_valid), 32'h0);
      chk("rst_req_addr", 32'(req_addr), 32'h0);
      chk("rst_req_wdata", req_wdata, 32'h0);
      chk("rst_core_rst", 32'(core_rst), 32'h1);
      chk("rst_boot", boot_addr, 32'h8000_0000);
      chk("rst_irq", 32'(irq), 32'h0);

      // CSR table, issued back-to-back every two cycles
      for (int i = 0; i < 13; i++) begin
         csr_txn(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, a1, d1, a2);
         chk($sformatf("csr%0d_ack", i), 32'(a1), 32'h1);
         chk($sformatf("csr%0d_dat", i), d1, vecs[i].exp_dat);
         chk($sformatf("csr%0d_ack_one_cycle", i), 32'(a2), 32'h0);
         chk($sformatf("csr%0d_core_rst", i), 32'(core_rst), 32'(vecs[i].exp_core_rst));
         chk($sformatf("csr%0d_boot", i), boot_addr, vecs[i].exp_boot);
      end
      chk("csr_irq_idle", 32'(irq), 32'h0);

      // Region miss: never acked, never forwarded
      ack_cnt = 0; rv_cnt = 0;
      cyc = 1'b1; stb = 1'b1; adr = 32'h2000_0010;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (ack) ack_cnt++;
         if (req_valid) rv_cnt++;
      end
      cyc = 1'b0; stb = 1'b0;
      chk("miss_ack_count", 32'(ack_cnt), 32'h0);
      chk("miss_req_valid", 32'(rv_cnt), 32'h0);

      // Window read: ready in cycle 1, rsp in cycle 4, ack in cycle 5
      win_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1, 4, 0, 32'hCAFE_F00D, ack_c, d1, rv1, ra1, aa);
      chk("wrd_req_valid_c1", 32'(rv1), 32'h1);
      chk("wrd_req_addr", ra1, 32'h0000_0010);
      chk("wrd_ack_cycle", 32'(ack_c), 32'd5);
      chk("wrd_dat", d1, 32'hCAFE_F00D);
      chk("wrd_ack_one_cycle", 32'(aa), 32'h0);

      // Minimum-latency read: ack in cycle 3
      win_txn(1'b0, 32'h3000_0044, 32'h0, 4'hF, 1, 2, 0, 32'h0BAD_CAFE, ack_c, d1, rv1, ra1, aa);
      chk("wmin_ack_cycle", 32'(ack_c), 32'd3);
      chk("wmin_dat", d1, 32'h0BAD_CAFE);
      chk("wmin_req_addr", ra1, 32'h0000_0044);

      // Window write, ready never comes: timeout ack 9 cycles after stb
      win_txn(1'b1, 32'h3000_0020, 32'hA5A5_5A5A, 4'b0110, 0, 0, 0, 32'h0, ack_c, d1, rv1, ra1, aa);
      chk("wto_ack_cycle", 32'(ack_c), 32'd9);
      chk("wto_dat", d1, 32'h0);
      chk("wto_req_we", 32'(req_we), 32'h1);
      chk("wto_req_wdata", req_wdata, 32'hA5A5_5A5A);
      chk("wto_req_wstrb", 32'(req_wstrb), 32'h6);
      chk("wto_req_valid_after", 32'(req_valid), 32'h0);
      chk("wto_irq_disabled", 32'(irq), 32'h0);
      csr_txn(1'b0, 32'h3080_0008, 32'h0, 4'hF, a1, d1, a2);
      chk("wto_status", d1, 32'h0000_0101);
      csr_txn(1'b1, 32'h3080_0000, 32'h0000_0002, 4'b0001, a1, d1, a2);
      chk("irq_en_irq", 32'(irq), 32'h1);
      chk("irq_en_core_rst", 32'(core_rst), 32'h0);
      csr_txn(1'b1, 32'h3080_0008, 32'h0000_0001, 4'b0001, a1, d1, a2);
      chk("w1c_irq", 32'(irq), 32'h0);
      csr_txn(1'b0, 32'h3080_0008, 32'h0, 4'hF, a1, d1, a2);
      chk("w1c_status", d1, 32'h0000_0100);

      // Read timing out in WAIT returns DEAD_BEEF
      win_txn(1'b0, 32'h3000_0030, 32'h0, 4'hF, 1, 0, 0, 32'h0, ack_c, d1, rv1, ra1, aa);
      chk("rto_ack_cycle", 32'(ack_c), 32'd9);
      chk("rto_dat", d1, TIMEOUT_RDATA);
      chk("rto_irq", 32'(irq), 32'h1);
      csr_txn(1'b0, 32'h3080_0008, 32'h0, 4'hF, a1, d1, a2);
      chk("rto_status", d1, 32'h0000_0201);

      // Master drops cyc in WAIT, rsp then arrives: no ack, bridge recovers
      win_txn(1'b0, 32'h3000_0050, 32'h0, 4'hF, 1, 3, 2, 32'h1111_2222, ack_c, d1, rv1, ra1, aa);
      chk("drop_no_ack", 32'(ack_c), 32'hFFFF_FFFF);
      csr_txn(1'b0, 32'h3080_0004, 32'h0, 4'hF, a1, d1, a2);
      chk("drop_next_ack", 32'(a1), 32'h1);
      chk("drop_next_dat", d1, 32'h8034_0078);
      csr_txn(1'b0, 32'h3080_0008, 32'h0, 4'hF, a1, d1, a2);
      chk("drop_status_unchanged", d1, 32'h0000_0201);

      // Reset asserted while in REQ
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0060; sel = 4'hF;
      @(negedge clk);
      chk("rreq_req_valid", 32'(req_valid), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("rreq_req_valid_async", 32'(req_valid), 32'h0);
      chk("rreq_core_rst", 32'(core_rst), 32'h1);
      chk("rreq_boot", boot_addr, 32'h8000_0000);
      chk("rreq_irq", 32'(irq), 32'h0);
      chk("rreq_req_addr", 32'(req_addr), 32'h0);
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      rsp_valid = 1'b1; rsp_rdata = 32'h5555_AAAA;
      @(negedge clk);
      rsp_valid = 1'b0;
      ack_cnt = 0; rv_cnt = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (ack) ack_cnt++;
         if (req_valid) rv_cnt++;
      end
      chk("stray_rsp_ack", 32'(ack_cnt), 32'h0);
      chk("stray_rsp_req_valid", 32'(rv_cnt), 32'h0);
      csr_txn(1'b0, 32'h3080_0000, 32'h0, 4'hF, a1, d1, a2);
      chk("post_rst_ctrl_ack", 32'(a1), 32'h1);
      chk("post_rst_ctrl", d1, 32'h0000_0001);
      csr_txn(1'b0, 32'h3080_0008, 32'h0, 4'hF, a1, d1, a2);
      chk("post_rst_status", d1, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
